// File: rtl/board_window_server.sv
// rtl/board_window_server.sv - 15x15 Gomoku board store serving black/white line windows around a cell
//
// Optional build macro: WINDOW_REG_EN
//    defined     : the eight windows are registered (1-cycle latency from get_y/get_x)
//    not defined : the windows are combinational from get_y/get_x and board state

module board_window_server #(
   parameter int BOARD_SIZE = 15,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             place_valid,
   output logic             place_ready,
   input  logic [3:0]       place_y,
   input  logic [3:0]       place_x,
   input  logic             place_color,
   output logic             place_ok,
   output logic             place_err,
   input  logic [3:0]       get_y,
   input  logic [3:0]       get_x,
   output logic [8:0]       black_y,
   output logic [8:0]       black_x,
   output logic [8:0]       black_yx,
   output logic [8:0]       black_xy,
   output logic [8:0]       white_y,
   output logic [8:0]       white_x,
   output logic [8:0]       white_yx,
   output logic [8:0]       white_xy,
   output logic             busy,
   output logic [CNT_W-1:0] stone_count
);

   localparam logic [3:0]        LAST_ROW   = 4'(BOARD_SIZE - 1);
   localparam logic [CNT_W-1:0]  MAX_STONES = CNT_W'(BOARD_SIZE * BOARD_SIZE);
   localparam logic signed [5:0] EDGE       = 6'(BOARD_SIZE);

   typedef enum logic {
      S_IDLE     = 1'b0,
      S_CLEARING = 1'b1
   } state_t;

   state_t state_q, state_d;

   // One packed row per board line: occupancy and colour (1 = white)
   logic [BOARD_SIZE-1:0] occ_q [BOARD_SIZE];
   logic [BOARD_SIZE-1:0] col_q [BOARD_SIZE];

   logic [3:0] row_q;
   logic       in_range;
   logic       cell_empty;
   logic       accept;
   logic       do_write;
   logic       clear_done;

   // Placement qualification: a request is taken in IDLE unless clr wins the cycle
   always_comb begin
      in_range   = (place_y <= LAST_ROW) && (place_x <= LAST_ROW);
      cell_empty = 1'b0;
      if (in_range) begin
         cell_empty = !occ_q[place_y][place_x];
      end
      accept     = (state_q == S_IDLE) && place_valid && !clr;
      do_write   = accept && cell_empty;
      clear_done = (state_q == S_CLEARING) && !clr && (row_q == LAST_ROW);
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: clr always (re)starts the row sweep
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (clr) begin
               state_d = S_CLEARING;
            end
         end
         S_CLEARING: begin
            if (clr) begin
               state_d = S_CLEARING;
            end else if (row_q == LAST_ROW) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs; ready is held low while reset is asserted
   always_comb begin
      place_ready = rst && (state_q == S_IDLE);
      busy        = (state_q == S_CLEARING);
   end

   // Clear sweep row pointer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_q <= 4'd0;
      end else if (clr) begin
         row_q <= 4'd0;
      end else if (state_q == S_CLEARING) begin
         row_q <= (row_q == LAST_ROW) ? 4'd0 : row_q + 4'd1;
      end
   end

   // Board storage: one row wiped per clearing cycle, otherwise accepted stones are written
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ_q <= '{default: '0};
         col_q <= '{default: '0};
      end else if (state_q == S_CLEARING) begin
         occ_q[row_q] <= '0;
         col_q[row_q] <= '0;
      end else if (do_write) begin
         occ_q[place_y][place_x] <= 1'b1;
         col_q[place_y][place_x] <= place_color;
      end
   end

   // Stone counter, saturating at a full board and zeroed when the sweep finishes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stone_count <= '0;
      end else if (clear_done) begin
         stone_count <= '0;
      end else if (do_write && (stone_count != MAX_STONES)) begin
         stone_count <= stone_count + 1'b1;
      end
   end

   // Placement result pulses, one cycle after the request is taken
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         place_ok  <= 1'b0;
         place_err <= 1'b0;
      end else begin
         place_ok  <= do_write;
         place_err <= accept && !cell_empty;
      end
   end

   // Returns {black, white} for a cell; anything off the board reads as empty
   function automatic logic [1:0] cell_at(input logic signed [5:0] yy, input logic signed [5:0] xx);
      cell_at = 2'b00;
      if ((yy >= 6'sd0) && (yy < EDGE) && (xx >= 6'sd0) && (xx < EDGE)) begin
         if (occ_q[yy[3:0]][xx[3:0]]) begin
            cell_at = col_q[yy[3:0]][xx[3:0]] ? 2'b01 : 2'b10;
         end
      end
   endfunction

   // Widened signed centre so centre+offset never wraps back onto the board
   logic signed [5:0] gy;
   logic signed [5:0] gx;
   assign gy = $signed({2'b00, get_y});
   assign gx = $signed({2'b00, get_x});

   // raw_win order: black y, x, yx, xy, then white y, x, yx, xy
   logic [7:0][8:0] raw_win;
   logic [7:0][8:0] shown_win;

   for (genvar i = 0; i < 9; i++) begin : g_tap
      localparam logic signed [5:0] D = 6'(i - 4);
      logic [1:0] c_y, c_x, c_yx, c_xy;

      // Sample the four cells at offset D along each direction
      always_comb begin
         c_y  = cell_at(gy + D, gx);
         c_x  = cell_at(gy, gx + D);
         c_yx = cell_at(gy + D, gx + D);
         c_xy = cell_at(gy + D, gx - D);
      end

      assign raw_win[0][i] = c_y[1];
      assign raw_win[1][i] = c_x[1];
      assign raw_win[2][i] = c_yx[1];
      assign raw_win[3][i] = c_xy[1];
      assign raw_win[4][i] = c_y[0];
      assign raw_win[5][i] = c_x[0];
      assign raw_win[6][i] = c_yx[0];
      assign raw_win[7][i] = c_xy[0];
   end

`ifdef WINDOW_REG_EN
   logic [7:0][8:0] win_q;

   // Window pipeline register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_q <= '0;
      end else begin
         win_q <= raw_win;
      end
   end

   assign shown_win = busy ? '0 : win_q;
`else
   assign shown_win = busy ? '0 : raw_win;
`endif

   assign black_y  = shown_win[0];
   assign black_x  = shown_win[1];
   assign black_yx = shown_win[2];
   assign black_xy = shown_win[3];
   assign white_y  = shown_win[4];
   assign white_x  = shown_win[5];
   assign white_yx = shown_win[6];
   assign white_xy = shown_win[7];

endmodule

// File: tb/tb_board_window_server.sv
// tb/tb_board_window_server.sv - randomized self-checking bench for board_window_server

module tb_board_window_server;

   localparam int N = 15;
`ifdef WINDOW_REG_EN
   localparam int WLAT = 1;
`else
   localparam int WLAT = 0;
`endif

   logic       clk;
   logic       rst;
   logic       clr;
   logic       place_valid;
   logic       place_ready;
   logic [3:0] place_y;
   logic [3:0] place_x;
   logic       place_color;
   logic       place_ok;
   logic       place_err;
   logic [3:0] get_y;
   logic [3:0] get_x;
   logic [8:0] black_y, black_x, black_yx, black_xy;
   logic [8:0] white_y, white_x, white_yx, white_xy;
   logic       busy;
   logic [7:0] stone_count;

   board_window_server #(.BOARD_SIZE(15), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .place_valid(place_valid), .place_ready(place_ready),
      .place_y(place_y), .place_x(place_x), .place_color(place_color),
      .place_ok(place_ok), .place_err(place_err),
      .get_y(get_y), .get_x(get_x),
      .black_y(black_y), .black_x(black_x), .black_yx(black_yx), .black_xy(black_xy),
      .white_y(white_y), .white_x(white_x), .white_yx(white_yx), .white_xy(white_xy),
      .busy(busy), .stone_count(stone_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference board: plain arrays filled by the placement rules
   bit m_occ [N][N];
   bit m_col [N][N];
   int m_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // dir: 0 = y, 1 = x, 2 = yx, 3 = xy
   function automatic logic [8:0] model_win(input int y, input int x, input int dir, input bit white);
      logic [8:0] w;
      w = '0;
      for (int d = -4; d <= 4; d++) begin
         int cy, cx;
         cy = y;
         cx = x;
         case (dir)
            0:       cy = y + d;
            1:       cx = x + d;
            2:       begin cy = y + d; cx = x + d; end
            default: begin cy = y + d; cx = x - d; end
         endcase
         if (cy >= 0 && cy < N && cx >= 0 && cx < N) begin
            if (m_occ[cy][cx] && (m_col[cy][cx] == white)) w[d + 4] = 1'b1;
         end
      end
      return w;
   endfunction

   task automatic model_clear();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            m_occ[r][c] = 1'b0;
            m_col[r][c] = 1'b0;
         end
      m_cnt = 0;
   endtask

   task automatic check_windows(input int y, input int x, input string tag);
      get_y = 4'(y);
      get_x = 4'(x);
      if (WLAT != 0) begin
         @(posedge clk);
         #1;
      end else begin
         #1;
      end
      check($sformatf("%s black_y(%0d,%0d)", tag, y, x),  black_y,  model_win(y, x, 0, 1'b0));
      check($sformatf("%s black_x(%0d,%0d)", tag, y, x),  black_x,  model_win(y, x, 1, 1'b0));
      check($sformatf("%s black_yx(%0d,%0d)", tag, y, x), black_yx, model_win(y, x, 2, 1'b0));
      check($sformatf("%s black_xy(%0d,%0d)", tag, y, x), black_xy, model_win(y, x, 3, 1'b0));
      check($sformatf("%s white_y(%0d,%0d)", tag, y, x),  white_y,  model_win(y, x, 0, 1'b1));
      check($sformatf("%s white_x(%0d,%0d)", tag, y, x),  white_x,  model_win(y, x, 1, 1'b1));
      check($sformatf("%s white_yx(%0d,%0d)", tag, y, x), white_yx, model_win(y, x, 2, 1'b1));
      check($sformatf("%s white_xy(%0d,%0d)", tag, y, x), white_xy, model_win(y, x, 3, 1'b1));
   endtask

   // One placement per call; consecutive calls give back-to-back requests
   task automatic place(input int y, input int x, input bit c);
      bit legal;
      legal = 1'b0;
      if (y < N && x < N) legal = !m_occ[y][x];
      place_valid = 1'b1;
      place_y     = 4'(y);
      place_x     = 4'(x);
      place_color = c;
      @(posedge clk);
      #1;
      place_valid = 1'b0;
      check($sformatf("place_ok(%0d,%0d)", y, x),  place_ok,  legal);
      check($sformatf("place_err(%0d,%0d)", y, x), place_err, !legal);
      if (legal) begin
         m_occ[y][x] = 1'b1;
         m_col[y][x] = c;
         if (m_cnt < N * N) m_cnt++;
      end
      check("stone_count", stone_count, m_cnt);
   endtask

   initial begin
      int cyc;
      rst = 1'b0; clr = 1'b0; place_valid = 1'b0;
      place_y = '0; place_x = '0; place_color = 1'b0;
      get_y = 4'd7; get_x = 4'd7;
      model_clear();

      // Reset and release
      repeat (3) @(posedge clk);
      #1;
      check("ready_in_reset", place_ready, 1'b0);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      check("reset stone_count", stone_count, 0);
      check("reset place_ready", place_ready, 1'b1);
      check("reset busy", busy, 1'b0);
      check("reset place_ok", place_ok, 1'b0);
      check("reset place_err", place_err, 1'b0);
      check_windows(7, 7, "reset");

      // Black row of five, back to back
      for (int x = 3; x <= 7; x++) place(7, x, 1'b0);
      check("five stone_count", stone_count, 5);
      check_windows(7, 7, "five");
      check("five black_x literal", black_x, 9'b000011111);
      check("five black_y literal", black_y, 9'b000010000);

      // White in the corner, off-board taps read 0
      place(0, 0, 1'b1);
      check_windows(0, 0, "corner");
      check("corner white_yx literal", white_yx, 9'b000010000);
      check_windows(4, 4, "diag");
      check("diag white_yx literal", white_yx, 9'b000000001);

      // Rejected placements: occupied and out of range
      place(7, 7, 1'b0);
      place(15, 2, 1'b0);
      place(3, 15, 1'b1);
      check("err stone_count", stone_count, 6);
      check_windows(7, 7, "after_err");

`ifndef WINDOW_REG_EN
      // A write is not visible on the same cycle it is accepted
      get_y = 4'd7; get_x = 4'd8;
      place_valid = 1'b1; place_y = 4'd7; place_x = 4'd8; place_color = 1'b0;
      #1;
      check("same_cycle old black_x", black_x, model_win(7, 8, 1, 1'b0));
      @(posedge clk);
      #1;
      place_valid = 1'b0;
      check("same_cycle place_ok", place_ok, 1'b1);
      m_occ[7][8] = 1'b1; m_col[7][8] = 1'b0; m_cnt++;
      check("same_cycle new black_x", black_x, model_win(7, 8, 1, 1'b0));
`else
      // Registered windows lag the coordinate by one cycle
      check_windows(0, 0, "lag_pre");
      get_y = 4'd7; get_x = 4'd7;
      #1;
      check("lag old black_x", black_x, model_win(0, 0, 1, 1'b0));
      @(posedge clk);
      #1;
      check("lag new black_x", black_x, model_win(7, 7, 1, 1'b0));
`endif

      // Random placements and random window probes
      repeat (60) place($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
      repeat (25) check_windows($urandom_range(0, 15), $urandom_range(0, 15), "rand");

      // Clear with a same-cycle placement that must be dropped
      clr = 1'b1; place_valid = 1'b1; place_y = 4'd1; place_x = 4'd1; place_color = 1'b0;
      @(posedge clk);
      #1;
      clr = 1'b0; place_valid = 1'b0;
      cyc = 0;
      while (busy && cyc < 40) begin
         get_y = 4'($urandom_range(0, 14));
         get_x = 4'($urandom_range(0, 14));
         #1;
         check("busy windows zero", {black_y | black_x | black_yx | black_xy | white_y | white_x | white_yx | white_xy}, 0);
         check("busy no pulses", {place_ok, place_err}, 0);
         check("busy ready low", place_ready, 1'b0);
         cyc++;
         @(posedge clk);
         #1;
      end
      check("busy cycles", cyc, 15);
      model_clear();
      check("clear stone_count", stone_count, 0);
      check_windows(7, 7, "cleared");
      repeat (5) check_windows($urandom_range(0, 14), $urandom_range(0, 14), "cleared_rand");

      // Reset in the middle of a clear sweep
      place(7, 7, 1'b1);
      place(7, 6, 1'b1);
      get_y = 4'd7; get_x = 4'd7;
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      repeat (6) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("midclear busy", busy, 1'b0);
      check("midclear ready", place_ready, 1'b0);
      check("midclear stone_count", stone_count, 0);
      check("midclear pulses", {place_ok, place_err}, 0);
      check("midclear windows", {black_x | white_x | white_y | white_yx}, 0);
      model_clear();
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      check("post reset ready", place_ready, 1'b1);
      check_windows(7, 7, "post_reset");
      place(7, 7, 1'b0);
      check_windows(7, 7, "post_reset_place");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/board_window_server.md
Name: board_window_server

Overview:
- Owns the 15x15 Gomoku board state and serves per-cell line windows to the win-scan logic.
- The scanner drives a cell coordinate (get_y, get_x). This block returns eight 9-bit windows: black and white, each in four directions, centred on that cell.
- Also accepts stone placements through a valid/ready handshake, and performs a sequenced board clear.

Parameters:
- BOARD_SIZE, 15, board edge length in cells; coordinates valid 0..BOARD_SIZE-1.
- CNT_W, 8, width of stone_count; must hold BOARD_SIZE*BOARD_SIZE.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- clr  input  1  synchronous clear request, single-cycle pulse
- place_valid  input  1  placement request valid
- place_ready  output  1  block can accept a placement this cycle
- place_y  input  4  placement row
- place_x  input  4  placement column
- place_color  input  1  0 = black, 1 = white
- place_ok  output  1  one-cycle pulse: stone written
- place_err  output  1  one-cycle pulse: placement rejected
- get_y  input  4  window centre row
- get_x  input  4  window centre column
- black_y, black_x, black_yx, black_xy  output  9 each  black-stone windows
- white_y, white_x, white_yx, white_xy  output  9 each  white-stone windows
- busy  output  1  clear sequence in progress
- stone_count  output  CNT_W  stones currently on board

Behaviour:
- Storage: 225 cells, 2 bits each (occupied, colour). Registered; no RAM inference required.
- Reset values (async, rst=0): all cells empty, state IDLE, place_ready=0 during reset, place_ok=0, place_err=0, busy=0, stone_count=0, clear row counter=0.
- Windows: bit 4 is the centre cell; bit i is the cell at offset d=i-4, d from -4 to +4.
  - y: cell (get_y+d, get_x)
  - x: cell (get_y, get_x+d)
  - yx: cell (get_y+d, get_x+d)
  - xy: cell (get_y+d, get_x-d)
  - A black_* bit is 1 iff the cell is occupied and black; a white_* bit is 1 iff the cell is occupied and white.
  - Any cell with a coordinate outside 0..14 (including get_y/get_x >= 15) reads 0. Index arithmetic must be signed or widened to 5+ bits so there is no wrap-around.
- Window latency: combinational from get_y/get_x and board state (0 cycles). The scanner samples in the same cycle it drives the coordinate.
- While busy=1, all window outputs are forced to 0.
- State machine:
  - IDLE
    - place_ready=1.
    - On clr: go to CLEARING with row=0, busy=1. clr has priority over a same-cycle place_valid; that placement is dropped with no ok/err pulse.
    - On place_valid (no clr):
      - If coordinates are in range and the cell is empty: write the cell and pulse place_ok next cycle. stone_count increments, saturating at 225.
      - Otherwise: leave the cell unchanged and pulse place_err next cycle.
      - Placement is accepted every IDLE cycle; back-to-back placements are allowed.
  - CLEARING
    - place_ready=0; place_valid is ignored.
    - Each cycle, clear all 15 cells of row `row`, then row++.
    - After clearing row 14: set stone_count=0, busy=0, return to IDLE. Total 15 cycles busy.
    - clr while CLEARING restarts at row 0.
- A write becomes visible on the windows the cycle after acceptance. A same-cycle get on the written cell returns the old value.
- Async reset mid-clear or mid-placement aborts immediately to the reset values.

Optional Feature:
- WINDOW_REG_EN defined:
  - All eight windows are registered, with 1-cycle latency from get_y/get_x.
  - The forced-zero during busy applies to the registered value.
  - Reset value of the window registers is 0.
- Not defined: combinational windows as above.

Test Plan:
- Reset release, get (7,7) -> all windows 0, stone_count=0, place_ready=1, busy=0.
- Place black at (7,3),(7,4),(7,5),(7,6),(7,7), one per cycle -> five place_ok pulses, stone_count=5. Get (7,7) -> black_x=9'b000011111, black_y=9'b000010000, all white_* = 0.
- Place white at (0,0); get (0,0) -> white_yx=9'b000010000 (lower bits off-board read 0). Get (4,4) -> white_yx=9'b000000001.
- Place black at an occupied cell (7,7), then at (15,2) -> two place_err pulses, board and stone_count unchanged.
- Pulse clr with place_valid high in the same cycle -> no ok/err; busy high exactly 15 cycles; windows 0 throughout. Afterwards stone_count=0 and get (7,7) -> all 0.
- Assert rst low at clear cycle 6 -> outputs return to reset values immediately. With WINDOW_REG_EN defined, repeat scenario 2 and check the windows lag get by one cycle.
